// File: rtl/gestor_solicitudes_if.sv
// Request-manager bus: button presses, floor/door status in; instruction code,
// pending bitmap and busy flag out.
interface gestor_solicitudes_if;
  logic       en;
  logic       agregar;
  logic [3:0] boton_pres;
  logic [1:0] piso;
  logic       puertas;
  logic [3:0] memoria;
  logic [9:0] pendientes;
  logic       ocupado;

  modport master (
    output en, agregar, boton_pres, piso, puertas,
    input  memoria, pendientes, ocupado
  );

  modport slave (
    input  en, agregar, boton_pres, piso, puertas,
    output memoria, pendientes, ocupado
  );
endinterface

// File: rtl/gestor_solicitudes.sv
// Elevator request manager: latches button presses, picks the next target with
// a direction-preserving SCAN policy and clears a floor after the door dwell.
module gestor_solicitudes #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned CW           = 4
) (
  input logic                 clk,
  input logic                 rst,
  gestor_solicitudes_if.slave bus
);
  localparam int unsigned NCODE  = 10;
  localparam int unsigned NFLOOR = 4;

  typedef enum logic [1:0] {S_IDLE, S_SERVING, S_DWELL} state_t;

  state_t            r_state, w_state_n;
  logic [3:0]        r_mem, w_mem_n;
  logic [NCODE-1:0]  r_pend, w_pend_n, w_set, w_clr;
  logic              r_ocup, w_ocup_n;
  logic              r_dir_up, w_dir_up_n;
  logic [CW-1:0]     r_cnt, w_cnt_n, w_cnt_base;
  logic [1:0]        r_tgt, w_tgt_n;
  logic [NFLOOR-1:0] w_floor_pend;
  logic [1:0]        w_above, w_below, w_sel;
  logic              w_has_above, w_has_below;
  logic              w_at_tgt;

  // Codes belonging to each floor: cabin button plus its hall buttons.
  function automatic logic [NCODE-1:0] floor_mask(input logic [1:0] floor);
    unique case (floor)
      2'd0:    floor_mask = 10'h011;
      2'd1:    floor_mask = 10'h062;
      2'd2:    floor_mask = 10'h184;
      default: floor_mask = 10'h208;
    endcase
  endfunction

  function automatic logic [3:0] lowest_code(input logic [NCODE-1:0] pend,
                                             input logic [1:0]       floor);
    logic [NCODE-1:0] m;
    lowest_code = '0;
    m = pend & floor_mask(floor);
    for (int k = 0; k < NCODE; k++)
      if (m[k] && (lowest_code == 4'd0)) lowest_code = 4'(k + 1);
  endfunction

  // Nearest pending floor above (first found) and below (last found).
  always_comb begin
    w_floor_pend = '0;
    w_has_above  = 1'b0;
    w_above      = '0;
    w_has_below  = 1'b0;
    w_below      = '0;
    for (int f = 0; f < NFLOOR; f++) begin
      w_floor_pend[f] = |(r_pend & floor_mask(2'(f)));
      if (!w_has_above && w_floor_pend[f] && (2'(f) > bus.piso)) begin
        w_has_above = 1'b1;
        w_above     = 2'(f);
      end
      if (w_floor_pend[f] && (2'(f) < bus.piso)) begin
        w_has_below = 1'b1;
        w_below     = 2'(f);
      end
    end
  end

  always_comb begin
    w_sel = bus.piso;
    if (w_floor_pend[bus.piso])
      w_sel = bus.piso;
    else if (r_dir_up ? w_has_above : w_has_below)
      w_sel = r_dir_up ? w_above : w_below;
    else
      w_sel = r_dir_up ? w_below : w_above;
  end

  assign w_at_tgt   = bus.puertas && (bus.piso == r_tgt);
  assign w_cnt_base = (r_state == S_DWELL) ? (r_cnt + CW'(1)) : CW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_n  = r_state;
    w_mem_n    = r_mem;
    w_ocup_n   = r_ocup;
    w_dir_up_n = r_dir_up;
    w_cnt_n    = r_cnt;
    w_tgt_n    = r_tgt;
    w_clr      = '0;
    if (bus.en) begin
      unique case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            w_tgt_n   = w_sel;
            w_mem_n   = lowest_code(r_pend, w_sel);
            w_ocup_n  = 1'b1;
            w_state_n = S_SERVING;
            if (w_sel > bus.piso)      w_dir_up_n = 1'b1;
            else if (w_sel < bus.piso) w_dir_up_n = 1'b0;
          end else begin
            w_mem_n = '0;
          end
        end
        S_SERVING, S_DWELL: begin
          if (!w_at_tgt) begin
            w_state_n = S_SERVING;
            w_cnt_n   = '0;
          end else if (w_cnt_base == CW'(DWELL_CYCLES)) begin
            w_clr     = floor_mask(r_tgt);
            w_mem_n   = '0;
            w_ocup_n  = 1'b0;
            w_cnt_n   = '0;
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_DWELL;
            w_cnt_n   = w_cnt_base;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // A press landing on the clearing edge survives the clear.
  assign w_set = (bus.agregar && (bus.boton_pres >= 4'd1) && (bus.boton_pres <= 4'(NCODE)))
               ? (NCODE'(1) << (bus.boton_pres - 4'd1)) : '0;
  assign w_pend_n = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mem    <= '0;
      r_pend   <= '0;
      r_ocup   <= 1'b0;
      r_dir_up <= 1'b1;
      r_cnt    <= '0;
      r_tgt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_mem    <= w_mem_n;
      r_pend   <= w_pend_n;
      r_ocup   <= w_ocup_n;
      r_dir_up <= w_dir_up_n;
      r_cnt    <= w_cnt_n;
      r_tgt    <= w_tgt_n;
    end
  end

  assign bus.memoria    = r_mem;
  assign bus.pendientes = r_pend;
  assign bus.ocupado    = r_ocup;
endmodule

// File: tb/tb_gestor_solicitudes.sv
// Bench for gestor_solicitudes: directed vector table, hand-written dwell/reset
// sequences and randomized traffic against a floor-level reference model.
module tb_gestor_solicitudes;
  localparam int unsigned DWELL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gestor_solicitudes_if bus();

  gestor_solicitudes #(.DWELL_CYCLES(DWELL), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending set, current target floor, open-door run length.
  logic [9:0] m_pend;
  logic [3:0] m_mem;
  bit         m_busy;
  int         m_tgt;
  bit         m_up;
  int         m_run;

  function automatic int floor_of(int code);
    if (code == 1 || code == 5) return 0;
    if (code == 2 || code == 6 || code == 7) return 1;
    if (code == 3 || code == 8 || code == 9) return 2;
    return 3;
  endfunction

  function automatic bit floor_has(logic [9:0] p, int f);
    for (int c = 1; c <= 10; c++)
      if (p[c-1] && floor_of(c) == f) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mem = '0; m_busy = 1'b0; m_tgt = 0; m_up = 1'b1; m_run = 0;
  endtask

  task automatic model_step(bit r, bit e, bit a, int code, int p, bit pu);
    int t;
    int f;
    if (!r) begin
      model_reset();
      return;
    end
    if (e) begin
      if (!m_busy) begin
        if (m_pend != 0) begin
          t = -1;
          if (floor_has(m_pend, p)) t = p;
          for (int d = 1; d < 4 && t < 0; d++) begin
            f = m_up ? p + d : p - d;
            if (f >= 0 && f < 4 && floor_has(m_pend, f)) t = f;
          end
          for (int d = 1; d < 4 && t < 0; d++) begin
            f = m_up ? p - d : p + d;
            if (f >= 0 && f < 4 && floor_has(m_pend, f)) t = f;
          end
          if (t > p) m_up = 1'b1;
          else if (t < p) m_up = 1'b0;
          m_tgt  = t;
          m_busy = 1'b1;
          m_run  = 0;
          for (int c = 10; c >= 1; c--)
            if (m_pend[c-1] && floor_of(c) == t) m_mem = 4'(c);
        end
      end else if (pu && p == m_tgt) begin
        m_run++;
        if (m_run == int'(DWELL)) begin
          for (int c = 1; c <= 10; c++)
            if (floor_of(c) == m_tgt) m_pend[c-1] = 1'b0;
          m_busy = 1'b0;
          m_mem  = '0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (a && code >= 1 && code <= 10) m_pend[code-1] = 1'b1;
  endtask

  task automatic step(bit r, bit e, bit a, int code, int p, bit pu);
    rst            = r;
    bus.en         = e;
    bus.agregar    = a;
    bus.boton_pres = 4'(code);
    bus.piso       = 2'(p);
    bus.puertas    = pu;
    model_step(r, e, a, code, p, pu);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm, int mem, int pend, bit oc);
    check({nm, "_memoria"},    32'(bus.memoria),    32'(mem));
    check({nm, "_pendientes"}, 32'(bus.pendientes), 32'(pend));
    check({nm, "_ocupado"},    32'(bus.ocupado),    32'(oc));
  endtask

  typedef struct {
    bit en; bit agr; int code; int piso; bit pu;
    int mem; int pend; bit ocup;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, bit e, bit a, int code, int p, bit pu,
                              int mem, int pend, bit oc);
    vec_t v;
    v.en = e; v.agr = a; v.code = code; v.piso = p; v.pu = pu;
    v.mem = mem; v.pend = pend; v.ocup = oc;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  bit r_b, e_b, a_b, pu_b;
  int code_i, p_i;

  initial begin
    // n, en, agr, code, piso, puertas, memoria, pendientes, ocupado
    add(1, 1, 1, 3, 0, 0, 0, 'h004, 0);
    add(1, 1, 0, 0, 0, 0, 3, 'h004, 1);
    add(4, 1, 0, 0, 2, 1, 3, 'h004, 1);
    add(1, 1, 0, 0, 2, 0, 3, 'h004, 1);
    add(7, 1, 0, 0, 2, 1, 3, 'h004, 1);
    add(1, 1, 0, 0, 2, 1, 0, 'h000, 0);
    add(1, 1, 1, 0, 2, 0, 0, 'h000, 0);
    add(1, 1, 1, 11, 2, 0, 0, 'h000, 0);
    add(1, 1, 1, 15, 2, 0, 0, 'h000, 0);
    add(1, 0, 1, 2, 0, 0, 0, 'h002, 0);
    add(1, 0, 0, 0, 0, 0, 0, 'h002, 0);
    add(1, 1, 0, 0, 0, 0, 2, 'h002, 1);
    add(7, 1, 0, 0, 1, 1, 2, 'h002, 1);
    add(1, 1, 0, 0, 1, 1, 0, 'h000, 0);
    add(1, 0, 1, 1, 1, 0, 0, 'h001, 0);
    add(1, 0, 1, 4, 1, 0, 0, 'h009, 0);
    add(1, 1, 0, 0, 1, 0, 4, 'h009, 1);
    add(7, 1, 0, 0, 3, 1, 4, 'h009, 1);
    add(1, 1, 0, 0, 3, 1, 0, 'h001, 0);
    add(1, 1, 0, 0, 3, 0, 1, 'h001, 1);
    add(7, 1, 0, 0, 0, 1, 1, 'h001, 1);
    add(1, 1, 0, 0, 0, 1, 0, 'h000, 0);
    add(1, 0, 1, 9, 2, 0, 0, 'h100, 0);
    add(1, 1, 1, 2, 2, 0, 9, 'h102, 1);
    add(7, 1, 0, 0, 2, 1, 9, 'h102, 1);
    add(1, 1, 1, 3, 2, 1, 0, 'h006, 0);
    add(1, 1, 0, 0, 2, 0, 3, 'h006, 1);
    add(1, 1, 1, 10, 2, 0, 3, 'h206, 1);
    add(2, 1, 0, 0, 2, 1, 3, 'h206, 1);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("reset", 0, 0, 0);

    foreach (tbl[i]) begin
      step(1, tbl[i].en, tbl[i].agr, tbl[i].code, tbl[i].piso, tbl[i].pu);
      check_all($sformatf("tbl%0d", i), tbl[i].mem, tbl[i].pend, tbl[i].ocup);
    end

    // Reset while dwelling at floor 2, with a press that must be dropped.
    step(0, 0, 1, 5, 2, 1);
    check_all("rst_in_dwell", 0, 0, 0);

    // Dwell count freezes under en=0 and resumes where it left off.
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check_all("frz_sel", 1, 'h001, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1);
    check_all("frz_hold", 1, 'h001, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1);
    check_all("frz_before", 1, 'h001, 1);
    step(1, 1, 0, 0, 0, 1);
    check_all("frz_clear", 0, 0, 0);

    // Randomized traffic against the reference model.
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r_b    = ($urandom_range(0, 999) != 0);
      e_b    = ($urandom_range(0, 9) != 0);
      a_b    = ($urandom_range(0, 3) == 0);
      code_i = int'($urandom_range(0, 15));
      p_i    = (m_busy && $urandom_range(0, 9) != 0) ? m_tgt : int'($urandom_range(0, 3));
      pu_b   = ($urandom_range(0, 9) != 0);
      step(r_b, e_b, a_b, code_i, p_i, pu_b);
      check_all($sformatf("rand%0d", i), int'(m_mem), int'(m_pend), m_busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
